// File: rtl/tick_gen_pkg.sv
// Shared constants and state encoding for the traffic light timebase.
// The default dividers are also used by the traffic light top level.
package tick_gen_pkg;

    localparam int unsigned DEF_DIV       = 50_000_000;
    localparam int unsigned DEF_FAST_DIV  = 5_000_000;
    localparam int unsigned DEF_DB_CYCLES = 500_000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        STEP  = 2'd2
    } state_t;

endpackage

// File: rtl/tick_gen_if.sv
// Control and status bundle between the timebase and its user.
// The master side drives run/fast/button; the slave side (tick_gen) answers with tick/paused.
interface tick_gen_if;

    logic run;
    logic fast;
    logic step_btn;
    logic tick;
    logic paused;

    modport master (
        output run,
        output fast,
        output step_btn,
        input  tick,
        input  paused
    );

    modport slave (
        input  run,
        input  fast,
        input  step_btn,
        output tick,
        output paused
    );

endinterface

// File: rtl/tick_gen_btn_debounce.sv
// Push-button conditioning: two-flop synchroniser, stability counter and a
// one-cycle pulse on every accepted press.
module btn_debounce
    import tick_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned DB_W      = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic rise
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_a;
    logic            btn_s;
    logic            btn_db_q;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            btn_s  <= sync_a;
        end
    end

    // A level change is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise = btn_db & ~btn_db_q;

endmodule

// File: rtl/tick_gen.sv
// Timebase for the traffic light controller: divides clk into a one-cycle tick,
// with a fast demo rate and single-stepping from a debounced button while paused.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned DIV       = DEF_DIV,
    parameter int unsigned FAST_DIV  = DEF_FAST_DIV,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned CNT_W     = $clog2(DIV),
    parameter int unsigned DB_W      = $clog2(DB_CYCLES)
) (
    input  logic      clk,
    input  logic      rst_n,
    tick_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DIV - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] limit_m1;
    logic             tick_q;
    logic             tick_nx;
    logic             paused_q;
    logic             paused_nx;
    logic             btn_db;
    logic             step_req;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.step_btn),
        .btn_db  (btn_db),
        .rise    (step_req)
    );

    assign limit_m1 = bus.fast ? FAST_M1 : DIV_M1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PAUSE;
            div_cnt  <= '0;
            tick_q   <= 1'b0;
            paused_q <= 1'b1;
        end else begin
            state    <= state_nx;
            div_cnt  <= cnt_nx;
            tick_q   <= tick_nx;
            paused_q <= paused_nx;
        end
    end

    // The >= compare lets a mid-count switch to the fast rate wrap at once.
    always_comb begin
        state_nx = state;
        cnt_nx   = div_cnt;
        tick_nx  = 1'b0;
        unique case (state)
            RUN: begin
                if (!bus.run) begin
                    state_nx = PAUSE;
                    cnt_nx   = '0;
                end else if (div_cnt >= limit_m1) begin
                    cnt_nx  = '0;
                    tick_nx = 1'b1;
                end else begin
                    cnt_nx = div_cnt + 1'b1;
                end
            end
            PAUSE: begin
                cnt_nx = '0;
                if (bus.run) begin
                    state_nx = RUN;
                end else if (step_req) begin
                    tick_nx  = 1'b1;
                    state_nx = STEP;
                end
            end
            STEP: begin
                cnt_nx = '0;
                if (bus.run) begin
                    state_nx = RUN;
                end else if (!btn_db) begin
                    state_nx = PAUSE;
                end
            end
            default: begin
                state_nx = PAUSE;
                cnt_nx   = '0;
            end
        endcase
        paused_nx = (state_nx != RUN);
    end

    assign bus.tick   = tick_q;
    assign bus.paused = paused_q;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen with small dividers: directed scenarios with literal
// expectations, then randomized run/fast/button activity against a reference model.
module tb_tick_gen;

    localparam int unsigned DIV       = 4;
    localparam int unsigned FAST_DIV  = 2;
    localparam int unsigned DB_CYCLES = 3;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    tick_gen_if tif();

    tick_gen #(
        .DIV       (DIV),
        .FAST_DIV  (FAST_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: free-running flag, stepping flag, edges since the last wrap,
    // and the history of raw button samples from which the debounced level is derived.
    bit m_running;
    bit m_stepping;
    int m_since;
    bit m_db;
    bit m_db_prev;
    bit hist[$];
    bit exp_tick   = 1'b0;
    bit exp_paused = 1'b1;
    int lim;
    bit rise;
    bit db_old;
    bit all_diff;

    task automatic model_reset();
        m_running  = 1'b0;
        m_stepping = 1'b0;
        m_since    = 0;
        m_db       = 1'b0;
        m_db_prev  = 1'b0;
        exp_tick   = 1'b0;
        exp_paused = 1'b1;
        hist       = {};
        for (int i = 0; i < int'(DB_CYCLES) + 2; i++) hist.push_front(1'b0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            lim    = tif.fast ? int'(FAST_DIV) : int'(DIV);
            rise   = m_db && !m_db_prev;
            db_old = m_db;
            // synchronised level seen on the last DB_CYCLES edges = raw samples 2..DB_CYCLES+1 edges old
            all_diff = 1'b1;
            for (int i = 1; i <= int'(DB_CYCLES); i++)
                if (hist[i] == m_db) all_diff = 1'b0;
            m_db_prev = m_db;
            if (all_diff) m_db = !m_db;
            hist.push_front(tif.step_btn);
            void'(hist.pop_back());

            exp_tick = 1'b0;
            if (m_running) begin
                if (!tif.run) begin
                    m_running = 1'b0;
                    m_since   = 0;
                end else if (m_since + 1 >= lim) begin
                    exp_tick = 1'b1;
                    m_since  = 0;
                end else begin
                    m_since++;
                end
            end else if (tif.run) begin
                m_running  = 1'b1;
                m_stepping = 1'b0;
                m_since    = 0;
            end else if (m_stepping) begin
                if (!db_old) m_stepping = 1'b0;
            end else if (rise) begin
                exp_tick   = 1'b1;
                m_stepping = 1'b1;
            end
            exp_paused = !m_running;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("model_tick", int'(tif.tick), int'(exp_tick));
        check("model_paused", int'(tif.paused), int'(exp_paused));
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Expects reset just released with run=1, fast=0.
    task automatic expect_startup(input string tag);
        int nt;
        nt = 0;
        for (int e = 1; e <= 13; e++) begin
            edge1();
            if (e == 1) check({tag, "_paused_e1"}, int'(tif.paused), 0);
            check({tag, "_tick"}, int'(tif.tick), int'(e == 5 || e == 9 || e == 13));
            nt += int'(tif.tick);
        end
        check({tag, "_ntick"}, nt, 3);
    endtask

    initial begin
        int nt;
        vectors      = 0;
        errors       = 0;
        rst_n        = 1'b0;
        tif.run      = 1'b1;
        tif.fast     = 1'b0;
        tif.step_btn = 1'b0;

        // Scenario 1: start-up from reset
        repeat (3) edge1();
        check("rst_tick", int'(tif.tick), 0);
        check("rst_paused", int'(tif.paused), 1);
        rst_n = 1'b1;
        expect_startup("s1");

        // Scenario 2: fast mode switched in while the count is past the fast limit
        repeat (3) edge1();
        tif.fast = 1'b1;
        for (int k = 0; k < 5; k++) begin
            edge1();
            check("s2_fast_tick", int'(tif.tick), int'(k % 2 == 0));
        end
        tif.fast = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            edge1();
            check("s2_slow_tick", int'(tif.tick), int'(k == 4));
        end

        // Scenario 3: pause on the edge that would have ticked
        repeat (3) edge1();
        tif.run = 1'b0;
        edge1();
        check("s3_tick", int'(tif.tick), 0);
        check("s3_paused", int'(tif.paused), 1);
        nt = 0;
        repeat (20) begin
            edge1();
            nt += int'(tif.tick);
        end
        check("s3_quiet", nt, 0);

        // Scenario 4: bouncy press, hold, release in PAUSE
        tif.step_btn = 1'b1;
        edge1();
        tif.step_btn = 1'b0;
        edge1();
        tif.step_btn = 1'b1;
        nt = 0;
        for (int k = 3; k <= 12; k++) begin
            edge1();
            check("s4_step_tick", int'(tif.tick), int'(k == 8));
            nt += int'(tif.tick);
        end
        tif.step_btn = 1'b0;
        for (int k = 13; k <= 20; k++) begin
            edge1();
            nt += int'(tif.tick);
        end
        check("s4_one_tick", nt, 1);
        check("s4_paused", int'(tif.paused), 1);

        // Scenario 5: press, then resume while the button is still held
        tif.step_btn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            edge1();
            check("s5_step_tick", int'(tif.tick), int'(k == 6));
        end
        tif.run = 1'b1;
        edge1();
        check("s5_run_paused", int'(tif.paused), 0);
        check("s5_run_tick", int'(tif.tick), 0);
        for (int k = 8; k <= 15; k++) begin
            edge1();
            check("s5_run_tick", int'(tif.tick), int'(k == 11 || k == 15));
        end

        // Scenario 6: asynchronous reset right after a tick
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_tick", int'(tif.tick), 0);
        check("s6_async_paused", int'(tif.paused), 1);
        tif.step_btn = 1'b0;
        repeat (2) edge1();
        rst_n = 1'b1;
        expect_startup("s6");

        // Randomized activity
        for (int c = 0; c < 3000; c++) begin
            edge1();
            if ($urandom_range(39, 0) == 0) tif.run = ~tif.run;
            if ($urandom_range(29, 0) == 0) tif.fast = ~tif.fast;
            if ($urandom_range(6, 0) == 0) tif.step_btn = ~tif.step_btn;
            if ($urandom_range(499, 0) == 0) begin
                #2;
                rst_n = 1'b0;
                repeat (2) edge1();
                rst_n = 1'b1;
            end
        end

        edge1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
Upstream timebase for the two-road traffic light controller. Divides the system clock into a 1-cycle `tick` pulse (1 Hz in silicon) that drives the light phase counters. Also supports a fast mode for demos and simulation. When paused, a debounced push-button single-steps the controller one tick at a time.

Parameters:
DIV, 50_000_000, clk cycles per tick in normal mode (>=2)
FAST_DIV, 5_000_000, clk cycles per tick in fast mode (>=2, <=DIV)
DB_CYCLES, 500_000, consecutive stable cycles required to accept a button level change (>=2)
CNT_W, $clog2(DIV), width of the divide counter
DB_W, $clog2(DB_CYCLES), width of the debounce counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
run  in  1  level; 1 = free-running ticks, 0 = paused
fast  in  1  level; 1 = divide by FAST_DIV, 0 = divide by DIV
step_btn  in  1  raw asynchronous push-button, active-high, may bounce
tick  out  1  registered, 1-cycle pulse to traffic light controller
paused  out  1  registered; 1 when state != RUN

Behaviour:
- Reset (rst_n=0, async): state=PAUSE, div_cnt=0, tick=0, paused=1, sync flops=0, btn_db=0, btn_db_q=0, db_cnt=0.
- limit = fast ? FAST_DIV : DIV, evaluated every cycle.
- Button path: two-flop synchroniser -> btn_s.
  - db_cnt counts consecutive cycles with btn_s != btn_db; any cycle with btn_s == btn_db clears it.
  - When db_cnt == DB_CYCLES-1 and btn_s != btn_db: btn_db <= btn_s, db_cnt <= 0.
  - step_req = btn_db & ~btn_db_q (1 cycle per accepted press).
- States: RUN, PAUSE, STEP. tick defaults to 0 every edge unless set below.
- PAUSE:
  - div_cnt held at 0.
  - run=1 -> RUN.
  - else step_req=1 -> tick<=1, go STEP.
- STEP: div_cnt held at 0, no ticks.
  - run=1 -> RUN.
  - else btn_db=0 -> PAUSE.
  - Holding the button never produces more than one tick.
- RUN, run=1:
  - If div_cnt >= limit-1: div_cnt<=0, tick<=1.
  - Else div_cnt<=div_cnt+1.
  - The entry edge into RUN leaves div_cnt=0, so the first tick asserts limit edges after entry; period thereafter = limit edges exactly.
- RUN, run=0: -> PAUSE, div_cnt<=0, tick<=0. A tick that would fall on this edge is suppressed.
- step_req is ignored in RUN.
- fast toggled mid-count: the >= comparison wraps immediately if div_cnt already exceeds the new limit-1. The divide counter never overflows.
- run and step_req on the same edge while in PAUSE: run wins, no step tick.
- tick is never high on two consecutive cycles (limit >= 2).
- paused <= (next state != RUN), registered with state.
- Reset asserted mid-count or mid-press: immediate return to reset values. No tick is emitted on release.

Decomposition:
- Package tick_gen_pkg holds:
  - state encoding localparams RUN=2'd0, PAUSE=2'd1, STEP=2'd2;
  - default DIV/FAST_DIV/DB_CYCLES constants shared with the traffic light top-level and bench.
- One sub-module: btn_debounce (synchroniser + debounce counter + rising-edge pulse). Parameter DB_CYCLES; ports clk, rst_n, btn_raw, btn_db, rise.

Test Plan:
Bench parameters: DIV=4, FAST_DIV=2, DB_CYCLES=3.
1. Release rst_n with run=1, fast=0 -> paused falls after edge 1; tick high for one cycle after edges 5, 9, 13; exactly 3 ticks in 13 edges.
2. Free-run with run=1, then set fast=1 when div_cnt=3 -> wrap on the next edge with tick=1; subsequent ticks every 2 edges. Return fast=0 -> period 4.
3. Drop run=0 on the edge where div_cnt=3 -> no tick, paused=1, div_cnt=0, no further ticks for 20 cycles.
4. In PAUSE, press step_btn with a 1-cycle bounce, then hold high 10 cycles -> exactly one tick, about 2+3 edges after the stable level; state=STEP while held; back to PAUSE 5 edges after release.
5. In STEP with the button held, raise run=1 -> RUN next edge; first tick 4 edges later; the held button produces no extra ticks.
6. Assert rst_n=0 asynchronously mid-count with run=1 -> tick=0 and paused=1 immediately, before the next clk edge; after release, behaviour matches scenario 1.
